// File: rtl/delay_arbiter.sv
// Round-robin sequencer sharing one loadable down-counter among N_REQ requesters.
// Define DELAY_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module delay_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 3
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] delay,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [W-1:0]       cnt_q
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic [W-1:0]  dly_arr [N_REQ];

`ifndef DELAY_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_nxt;
  int            cand;
  logic [IW-1:0] cand_idx;

  assign idx_nxt = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif

  for (genvar j = 0; j < N_REQ; j++) begin : g_dly
    assign dly_arr[j] = delay[j*W +: W];
  end

  // Winner search: first requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
`ifdef DELAY_ARB_FIXED_PRIO_EN
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[IW'(k)]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
`else
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IW'(cand);
      if (!win_vld && req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
`endif
  end

  // req[idx] is a level handshake: held until done, dropping it in LOAD/RUN aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
`ifndef DELAY_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          idx_d   = win_idx;
          state_d = LOAD;
        end
      end
      LOAD, RUN: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifndef DELAY_ARB_FIXED_PRIO_EN
          ptr_d   = idx_nxt;
`endif
        end else if (state_q == LOAD) begin
          cnt_d   = dly_arr[idx_q];
          state_d = RUN;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifndef DELAY_ARB_FIXED_PRIO_EN
        ptr_d   = idx_nxt;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifndef DELAY_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifndef DELAY_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign gnt  = busy ? (N_REQ'(1) << idx_q) : '0;
  assign done = (state_q == DONE) ? (N_REQ'(1) << idx_q) : '0;

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: directed scenarios plus random traffic against a
// service-age reference model; honours DELAY_ARB_FIXED_PRIO_EN.
module tb_delay_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 3;

  logic               clk = 1'b0;
  logic               nrst;
  logic [N_REQ-1:0]   req   = '0;
  logic [N_REQ*W-1:0] delay = '0;
  logic [N_REQ-1:0]   gnt, done;
  logic               busy;
  logic [W-1:0]       cnt_q;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  delay_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk(clk), .nrst(nrst), .req(req), .delay(delay),
    .gnt(gnt), .done(done), .busy(busy), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(logic [N_REQ-1:0] v, int i);
    logic [N_REQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int dly_of(logic [N_REQ*W-1:0] v, int i);
    logic [N_REQ*W-1:0] t;
    t = v >> (i * W);
    return int'(t[W-1:0]);
  endfunction

  function automatic int pick(logic [N_REQ-1:0] r, int p);
    int base;
    base = p;
`ifdef DELAY_ARB_FIXED_PRIO_EN
    base = 0;
`endif
    for (int k = 0; k < N_REQ; k++)
      if (bit_at(r, (base + k) % N_REQ)) return (base + k) % N_REQ;
    return -1;
  endfunction

  // Model: a service is described by its owner and its age in cycles since grant.
  int m_busy = 0, m_owner = 0, m_age = 0, m_d = 0, m_ptr = 0;
  int m_win, m_dsel;
  logic m_req_own;
  logic [N_REQ-1:0] m_gnt, m_done;
  logic [W-1:0]     m_cnt;

  always_comb begin
    m_win     = pick(req, m_ptr);
    m_dsel    = dly_of(delay, m_owner);
    m_req_own = bit_at(req, m_owner);
    m_gnt     = (m_busy != 0) ? (N_REQ'(1) << m_owner) : '0;
    m_done    = (m_busy != 0 && m_age > 0 && m_age == m_d + 2) ? m_gnt : '0;
    m_cnt     = (m_busy != 0 && m_age >= 1 && m_age <= m_d + 1) ? W'(m_d - (m_age - 1)) : '0;
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_busy <= 0; m_owner <= 0; m_age <= 0; m_d <= 0; m_ptr <= 0;
    end else if (m_busy == 0) begin
      if (m_win >= 0) begin
        m_busy <= 1; m_owner <= m_win; m_age <= 0;
      end
    end else if ((m_age > 0 && m_age == m_d + 2) || !m_req_own) begin
      m_busy <= 0;
      m_ptr  <= (m_owner + 1) % N_REQ;
    end else begin
      if (m_age == 0) m_d <= m_dsel;
      m_age <= m_age + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic expect4(input string tag, input logic [N_REQ-1:0] g, input logic [N_REQ-1:0] dn,
                         input logic [W-1:0] c, input logic b);
    check({tag, "_gnt"},  32'(gnt),   32'(g));
    check({tag, "_done"}, 32'(done),  32'(dn));
    check({tag, "_cnt"},  32'(cnt_q), 32'(c));
    check({tag, "_busy"}, 32'(busy),  32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_gnt",  32'(gnt),   32'(m_gnt));
      check("mdl_done", 32'(done),  32'(m_done));
      check("mdl_cnt",  32'(cnt_q), 32'(m_cnt));
      check("mdl_busy", 32'(busy),  32'(m_busy != 0));
    end
  end

  int rr_exp [5];
  int rr_got [5];
  int nseen;
  logic [N_REQ-1:0] prev_g;
  bit seen;

  initial begin
`ifdef DELAY_ARB_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 2, 3, 0};
`endif
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    expect4("reset", '0, '0, '0, 1'b0);
    nrst   = 1'b1;
    chk_en = 1'b1;

    // Single request, delay 3.
    req = 4'b0001; delay = {3'd0, 3'd0, 3'd0, 3'd3};
    step(); expect4("s_e1", 4'b0001, '0, 3'd0, 1'b1);
    step(); expect4("s_e2", 4'b0001, '0, 3'd3, 1'b1);
    step(); expect4("s_e3", 4'b0001, '0, 3'd2, 1'b1);
    step(); expect4("s_e4", 4'b0001, '0, 3'd1, 1'b1);
    step(); expect4("s_e5", 4'b0001, '0, 3'd0, 1'b1);
    step(); expect4("s_e6", 4'b0001, 4'b0001, 3'd0, 1'b1);
    req = '0;
    step(); expect4("s_e7", '0, '0, 3'd0, 1'b0);

    // Zero delay on requester 2.
    req = 4'b0100; delay = '0;
    step(); expect4("z_e1", 4'b0100, '0, 3'd0, 1'b1);
    step(); expect4("z_e2", 4'b0100, '0, 3'd0, 1'b1);
    step(); expect4("z_e3", 4'b0100, 4'b0100, 3'd0, 1'b1);
    req = '0;
    step(); expect4("z_e4", '0, '0, 3'd0, 1'b0);

    // Asynchronous reset in the middle of a RUN.
    req = 4'b0010; delay = {3'd0, 3'd0, 3'd5, 3'd0};
    step(); step(); step();
    check("r_cnt_before", 32'(cnt_q), 32'd4);
    #2 nrst = 1'b0;
    #1 expect4("r_async", '0, '0, '0, 1'b0);
    @(negedge clk);
    req = 4'b1111; delay = {4{3'd1}};
    nrst = 1'b1;

    // Round-robin fairness with all requesters held.
    nseen = 0; prev_g = '0;
    for (int c = 0; c < 100 && nseen < 5; c++) begin
      step();
      if (gnt != '0 && prev_g == '0) begin
        for (int j = 0; j < N_REQ; j++) if (bit_at(gnt, j)) rr_got[nseen] = j;
        nseen++;
        if (nseen == 5) req = '0;
      end
      prev_g = gnt;
    end
    check("rr_count", 32'(nseen), 32'd5);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(rr_got[k]), 32'(rr_exp[k]));
    step(); step();

    // Abort requester 1 at cnt_q == 4.
    req = 4'b0010; delay = {3'd0, 3'd0, 3'd7, 3'd0};
    step(); expect4("a_e1", 4'b0010, '0, 3'd0, 1'b1);
    step(); expect4("a_e2", 4'b0010, '0, 3'd7, 1'b1);
    step(); step(); step();
    expect4("a_e5", 4'b0010, '0, 3'd4, 1'b1);
    req = '0;
    step(); expect4("a_abort", '0, '0, 3'd0, 1'b0);
    req = 4'b0101;
`ifdef DELAY_ARB_FIXED_PRIO_EN
    step(); check("a_next_gnt", 32'(gnt), 32'(4'b0001));
`else
    step(); check("a_next_gnt", 32'(gnt), 32'(4'b0100));
`endif
    req = '0;
    step(); step();

    // Pending requester 3 and delay change during requester 0's RUN.
    req = 4'b0001; delay = {3'd0, 3'd0, 3'd0, 3'd2};
    step(); expect4("p_e1", 4'b0001, '0, 3'd0, 1'b1);
    step(); expect4("p_e2", 4'b0001, '0, 3'd2, 1'b1);
    req = 4'b1001; delay = {3'd0, 3'd0, 3'd0, 3'd6};
    step(); expect4("p_e3", 4'b0001, '0, 3'd1, 1'b1);
    step(); expect4("p_e4", 4'b0001, '0, 3'd0, 1'b1);
    step(); expect4("p_e5", 4'b0001, 4'b0001, 3'd0, 1'b1);
    req = 4'b1000;
    step(); expect4("p_e6", '0, '0, 3'd0, 1'b0);
    step(); expect4("p_e7", 4'b1000, '0, 3'd0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (done != '0) seen = 1'b1;
    end
    check("p_done3_seen", 32'(seen), 32'd1);
    req = '0;
    step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        logic [N_REQ-1:0] m;
        m = N_REQ'(1) << i;
        if (bit_at(done, i)) req = req & ~m;
        else if (!bit_at(req, i) && $urandom_range(0, 3) == 0) req = req | m;
        else if (bit_at(req, i) && $urandom_range(0, 39) == 0) req = req & ~m;
      end
      if ($urandom_range(0, 3) == 0) delay = (N_REQ*W)'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 nrst = 1'b0;
        #1 expect4("rnd_rst", '0, '0, '0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
# delay_arbiter

Shares one W-bit loadable down-counter among N_REQ requesters, each asking for a programmable delay. The block arbitrates between requesters, grants the counter to one of them, loads that requester's delay value, counts it out, and signals completion. It sits beside the synchronous counter datapath as its sequencer and arbiter.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 3, counter and delay width in bits
- clk  input  1  clock, all state changes on rising edge
- nrst  input  1  reset, asynchronous, active-low
- req  input  N_REQ  request per requester; held high until its done pulse, or dropped to abort
- delay  input  N_REQ*W  delay per requester; requester i uses delay[i*W +: W]
- gnt  output  N_REQ  one-hot grant, or all zero
- done  output  N_REQ  one-cycle completion pulse, one-hot, or all zero
- busy  output  1  high whenever state is not IDLE
- cnt_q  output  W  current counter value

## Operation
- Reset values: state IDLE, cnt_q 0, gnt 0, done 0, busy 0, internal index 0, round-robin pointer 0.
- States:
  - IDLE: if any req bit is high, select winner i, latch index, go to LOAD; otherwise stay.
  - LOAD: cnt_q <= delay[i]; go to RUN.
  - RUN: if cnt_q == 0 go to DONE, else cnt_q <= cnt_q - 1.
  - DONE: go to IDLE.
- gnt[i] is high in LOAD, RUN and DONE. done[i] is high only in DONE.
- Arbitration is round-robin. The search starts at the pointer and wraps modulo N_REQ. On leaving DONE, or on an abort, pointer <= (i+1) mod N_REQ.
- Abort: in LOAD or RUN, if req[i] is low at a rising edge, go to IDLE. cnt_q <= 0, no done pulse, and the pointer advances. req is ignored in DONE.
- delay[i] is sampled only at the LOAD edge. Later changes have no effect on the service in progress.
- Decrement never wraps: in RUN at cnt_q == 0 the counter holds 0.
- req bits of non-granted requesters are ignored outside IDLE. They stay pending and are served later.
- nrst asserted in any state: outputs and state return to reset values immediately. No done pulse is produced.

## Timing
- Let req[i] be high in the cycle before edge E1, with the block in IDLE:
  - E1: LOAD, gnt[i] = 1.
  - E2: RUN, cnt_q = d.
  - E3 .. E(d+2): one decrement per edge.
  - E(d+3): DONE, done[i] = 1.
  - E(d+4): IDLE, gnt = 0.
- Grant to done latency is d+2 cycles. gnt stays high for d+3 cycles.
- The earliest next grant is at E(d+5), because IDLE always lasts at least one cycle.
- Outputs are functions of registered state only, with no combinational path from inputs.

## Configuration
- DELAY_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest requesting index always wins, and the pointer is neither used nor updated.
- Not defined: round-robin as described above.
- The port list is identical in both builds.

## Test plan
- Reset and single request:
  - Stimulus: nrst low, then high; req = 0001, delay[0] = 3.
  - Required: gnt = 0001 at E1; cnt_q = 3,2,1,0 at E2..E5; done = 0001 at E6 only; gnt = 0 at E7.
- Zero delay:
  - Stimulus: delay[2] = 0, req = 0100.
  - Required: LOAD at E1, RUN with cnt_q = 0 at E2, done[2] at E3.
- Round-robin fairness:
  - Stimulus: req = 1111 held continuously, all delays = 1.
  - Required: grant order 0,1,2,3,0. With DELAY_ARB_FIXED_PRIO_EN defined, grant order is 0,0,0.
- Abort:
  - Stimulus: req[1] granted with delay 7; req[1] dropped when cnt_q = 4.
  - Required: next edge gives IDLE, gnt = 0, cnt_q = 0, no done pulse; next winner search starts at index 2.
- Pending requester and delay change:
  - Stimulus: req[3] raised while req[0] is in RUN; delay[0] changed mid-RUN.
  - Required: req[0] count unaffected; req[3] granted one cycle after IDLE follows done[0].
- Reset mid-operation:
  - Stimulus: nrst pulsed low during RUN.
  - Required: all outputs 0 asynchronously, no done pulse, pointer = 0.
